ioctl_upload_responder: RTL

- Serves HPS ioctl upload read requests (save/NVRAM dump direction) from a shared synchronous RAM inside `system`.
- Returns bytes on `ioctl_din` and holds `ioctl_wait` high until each byte is valid.
- Complements the download path (`dn_addr`/`dn_data`/`dn_wr`).
- Sits between the `emu` top and `system`, arbitrating for the RAM port via a request/grant pair.

---
 rtl/ioctl_upload_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ioctl_upload_responder.sv
// HPS ioctl upload responder: serves save/NVRAM read strobes from a shared RAM port.
// Optional running checksum of delivered bytes is enabled with `define UPLOAD_CHECKSUM_EN.
module ioctl_upload_responder #(
  parameter logic [7:0] UPLOAD_INDEX = 8'd1,
  parameter int         ADDR_W       = 16,
  parameter int         SIZE         = 65536,
  parameter int         RD_LATENCY   = 2,
  parameter logic [7:0] FILL         = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic              ioctl_rd,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_grant,
  input  logic [7:0]        mem_data,
  output logic [7:0]        checksum,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, FILLD = 2'd3} state_t;

  localparam logic [25:0] SIZE_L = 26'(SIZE);
  localparam logic [3:0]  LAT_M1 = 4'(RD_LATENCY - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       sel;
  logic       accept;
  logic       in_range;

  assign sel        = ioctl_upload & (ioctl_index == UPLOAD_INDEX);
  assign accept     = sel & ioctl_rd & (state == IDLE);
  assign in_range   = {1'b0, ioctl_addr} < SIZE_L;
  assign ioctl_wait = (state != IDLE) | accept;
  assign dbg_state  = state;

  // RAM handshake: mem_rd is a request that stays high with mem_addr stable
  // until the first cycle mem_grant=1; that cycle is the transfer cycle and
  // mem_data is sampled RD_LATENCY cycles later.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ioctl_din <= 8'h00;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
    end else if ((state != IDLE) && !sel) begin
      // Session dropped mid-read: abandon without touching ioctl_din.
      state  <= IDLE;
      mem_rd <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_range) begin
              state    <= REQ;
              mem_rd   <= 1'b1;
              mem_addr <= ioctl_addr[ADDR_W-1:0];
            end else begin
              state     <= FILLD;
              ioctl_din <= FILL;
            end
          end
        end
        REQ: begin
          if (mem_grant) begin
            mem_rd <= 1'b0;
            cnt    <= LAT_M1;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            ioctl_din <= mem_data;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        FILLD:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UPLOAD_CHECKSUM_EN
  logic       sel_q;
  logic       deliver_fill;
  logic       deliver_ram;
  logic [7:0] sum_base;

  assign deliver_fill = accept & ~in_range;
  assign deliver_ram  = (state == WAIT) & sel & (cnt == 4'd0);
  // A new session starts the sum from zero, even if its first byte lands now.
  assign sum_base     = (sel & ~sel_q) ? 8'h00 : checksum;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sel_q    <= 1'b0;
      checksum <= 8'h00;
    end else begin
      sel_q <= sel;
      if (deliver_fill)
        checksum <= sum_base + FILL;
      else if (deliver_ram)
        checksum <= sum_base + mem_data;
      else
        checksum <= sum_base;
    end
  end
`else
  assign checksum = 8'h00;
`endif

endmodule
